// File: rtl/adder_operand_sequencer.sv
// Operand sequencer wrapping an external combinational adder: collects A then B from a byte
// stream, holds them on the adder inputs, captures the settled result and hands it downstream.
module adder_operand_sequencer #(
   parameter int DATA_W        = 8,
   parameter int SETTLE_CYCLES = 1,   // legal range 1..15
   parameter int CNT_W         = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] add_a,
   output logic [DATA_W-1:0] add_b,
   input  logic [DATA_W-1:0] add_sum,
   input  logic              add_cout,
   output logic [DATA_W-1:0] out_sum,
   output logic              out_cout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   localparam int SC_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      SETTLE,
      RESULT
   } state_t;

   state_t          state;
   logic [SC_W-1:0] settle_cnt;
   logic            accept;

   assign accept = in_valid & in_ready;

   // in_ready and busy are flops updated alongside every state transition, so no
   // input ever reaches an output combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         add_a      <= '0;
         add_b      <= '0;
         out_sum    <= '0;
         out_cout   <= 1'b0;
         out_valid  <= 1'b0;
         op_count   <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state    <= LOAD_A;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
            LOAD_A: begin
               if (accept) begin
                  add_a    <= in_data;
                  state    <= LOAD_B;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            LOAD_B: begin
               if (accept) begin
                  add_b      <= in_data;
                  settle_cnt <= SC_W'(SETTLE_CYCLES - 1);
                  state      <= SETTLE;
                  in_ready   <= 1'b0;
               end
            end
            SETTLE: begin
               // add_a/add_b have been stable since the B accept; sample once the count expires
               if (settle_cnt == '0) begin
                  out_sum   <= add_sum;
                  out_cout  <= add_cout;
                  out_valid <= 1'b1;
                  state     <= RESULT;
               end else begin
                  settle_cnt <= settle_cnt - SC_W'(1);
               end
            end
            RESULT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  op_count  <= op_count + CNT_W'(1);
                  state     <= LOAD_A;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Scoreboard bench for adder_operand_sequencer: a driver issues operand pairs and queues the
// expected {cout,sum} and capture cycle; a monitor checks every result the DUT presents.
module tb_adder_operand_sequencer;

   localparam int DATA_W = 8;
   localparam int SETTLE = 3;
   localparam int CNT_W  = 8;

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] add_a;
   logic [DATA_W-1:0] add_b;
   logic [DATA_W-1:0] add_sum;
   logic              add_cout;
   logic [DATA_W-1:0] out_sum;
   logic              out_cout;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic [CNT_W-1:0]  op_count;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   int n_ops = 0;
   bit rand_ready = 0;

   logic [DATA_W:0] res_q[$];
   int              lat_q[$];

   adder_operand_sequencer #(
      .DATA_W       (DATA_W),
      .SETTLE_CYCLES(SETTLE),
      .CNT_W        (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .out_sum  (out_sum),
      .out_cout (out_cout),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy),
      .op_count (op_count)
   );

   // behavioural stand-in for the carry-select adder
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard: samples 1 time unit after each falling edge.
   initial begin : monitor
      logic [CNT_W-1:0] exp_count;
      bit               prev_valid;
      int               n_res;
      exp_count  = '0;
      prev_valid = 1'b0;
      n_res      = 0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            res_q.delete();
            lat_q.delete();
            exp_count  = '0;
            prev_valid = 1'b0;
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_op_count",  32'(op_count), 0);
            check("rst_in_ready",  32'(in_ready), 0);
            check("rst_busy",      32'(busy), 0);
            check("rst_out_sum",   32'({out_cout, out_sum}), 0);
            check("rst_add_ab",    32'({add_a, add_b}), 0);
         end else begin
            check("op_count", 32'(op_count), 32'(exp_count));
            if (out_valid) begin
               if (!prev_valid) begin
                  if (lat_q.size() == 0) check("unexpected_valid", 1, 0);
                  else check("latency_edge", 32'(cycle), 32'(lat_q.pop_front()));
               end
               check("in_ready_in_result", 32'(in_ready), 0);
               check("busy_in_result", 32'(busy), 1);
               if (res_q.size() == 0) begin
                  check("result_without_op", 1, 0);
               end else begin
                  check("result", 32'({out_cout, out_sum}), 32'(res_q[0]));
                  if (out_ready) begin
                     n_res++;
                     $display("[TB] result %0d: sum=%02h cout=%0d", n_res, out_sum, out_cout);
                     void'(res_q.pop_front());
                     exp_count = exp_count + CNT_W'(1);
                  end
               end
            end
            prev_valid = out_valid;
         end
      end
   end

   task automatic send(input logic [DATA_W-1:0] d, output int acc);
      int guard;
      guard = 0;
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 0, 1);
         in_valid = 1'b0;
         acc = -1;
      end else begin
         acc = cycle + 1;
         @(posedge clk);
      end
   endtask

   task automatic op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      int acc;
      send(a, acc);
      if (acc < 0) return;
      send(b, acc);
      if (acc < 0) return;
      res_q.push_back({1'b0, a} + {1'b0, b});
      lat_q.push_back(acc + SETTLE);
      n_ops++;
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (res_q.size() != 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("drain_timeout", 32'(res_q.size()), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      n_ops = 0;
      #1 check("in_ready_after_release", 32'(in_ready), 0);
      @(negedge clk);
      #1 check("in_ready_one_cycle_later", 32'(in_ready), 1);
   endtask

   initial begin : driver
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 check("in_ready_after_release", 32'(in_ready), 0);
      @(negedge clk);
      #1 check("in_ready_one_cycle_later", 32'(in_ready), 1);

      op(8'h0F, 8'h01);
      op(8'hFF, 8'h01);
      op(8'h80, 8'h80);
      op(8'h7F, 8'h7F);
      drain();
      check("op_count_directed", 32'(op_count), 4);

      // backpressure: result must hold and the input side must stay closed
      out_ready = 1'b0;
      op(8'h5A, 8'hC3);
      begin
         int guard;
         guard = 0;
         while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         check("stall_valid_timeout", 32'(out_valid), 1);
      end
      repeat (5) begin
         @(negedge clk);
         in_data  = 8'($urandom);
         in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      check("add_a_held", 32'(add_a), 32'h5A);

      // reset during SETTLE discards the in-flight operation
      op(8'hAA, 8'h55);
      do_reset();
      op(8'h12, 8'h34);
      drain();
      check("op_count_after_reset", 32'(op_count), 1);

      // 256 back-to-back ops wrap the counter to zero
      do_reset();
      for (int i = 0; i < 256; i++) op(8'($urandom), 8'($urandom));
      drain();
      check("op_count_wrap", 32'(op_count), 0);

      // random consumer backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 60; i++) op(8'($urandom), 8'($urandom));
      drain();
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      check("op_count_final", 32'(op_count), 32'(n_ops % 256));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule
